// File: rtl/control_pkg.sv
// Shared types and MIPS opcode/funct/REGIMM-rt constants for the control FSM and its decoder.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC   = 3'd1,
        ST_MEM    = 3'd2,
        ST_MULDIV = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_PASS,
        ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
    } alu_op_t;

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
        logic r31;
        logic shamt;
    } ctrl_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MEM, CLS_MULDIV, CLS_JR, CLS_ILLEGAL
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: opcode/rt/funct to control bits, ALU op and instruction class.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [4:0] i_rt,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output alu_op_t    o_alu,
    output cls_t       o_cls
);

    always_comb begin
        o_ctrl = '0;
        o_alu  = ALU_PASS;
        o_cls  = CLS_ALU;
        case (i_op)
            OP_RTYPE: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                case (i_funct)
                    FN_SLL:           begin o_alu = ALU_SLL; o_ctrl.shamt = 1'b1; end
                    FN_SRL:           begin o_alu = ALU_SRL; o_ctrl.shamt = 1'b1; end
                    FN_SRA:           begin o_alu = ALU_SRA; o_ctrl.shamt = 1'b1; end
                    FN_SLLV:          o_alu = ALU_SLL;
                    FN_SRLV:          o_alu = ALU_SRL;
                    FN_SRAV:          o_alu = ALU_SRA;
                    FN_JR:            begin o_ctrl = '0; o_cls = CLS_JR; end
                    FN_JALR:          o_cls = CLS_JR;
                    FN_MFHI, FN_MFLO: o_alu = ALU_PASS;
                    FN_MTHI, FN_MTLO: o_ctrl = '0;
                    FN_MULT:          begin o_ctrl = '0; o_cls = CLS_MULDIV; o_alu = ALU_MULT;  end
                    FN_MULTU:         begin o_ctrl = '0; o_cls = CLS_MULDIV; o_alu = ALU_MULTU; end
                    FN_DIV:           begin o_ctrl = '0; o_cls = CLS_MULDIV; o_alu = ALU_DIV;   end
                    FN_DIVU:          begin o_ctrl = '0; o_cls = CLS_MULDIV; o_alu = ALU_DIVU;  end
                    FN_ADD, FN_ADDU:  o_alu = ALU_ADD;
                    FN_SUB, FN_SUBU:  o_alu = ALU_SUB;
                    FN_AND:           o_alu = ALU_AND;
                    FN_OR:            o_alu = ALU_OR;
                    FN_XOR:           o_alu = ALU_XOR;
                    FN_NOR:           o_alu = ALU_NOR;
                    FN_SLT:           o_alu = ALU_SLT;
                    FN_SLTU:          o_alu = ALU_SLTU;
                    default:          begin o_ctrl = '0; o_cls = CLS_ILLEGAL; end
                endcase
            end
            OP_REGIMM: begin
                case (i_rt)
                    RT_BLTZ, RT_BGEZ:     o_alu = ALU_SUB;
                    RT_BLTZAL, RT_BGEZAL: begin
                        o_alu = ALU_SUB; o_ctrl.reg_write = 1'b1; o_ctrl.r31 = 1'b1;
                    end
                    default:              o_cls = CLS_ILLEGAL;
                endcase
            end
            OP_J:    o_alu = ALU_PASS;
            OP_JAL:  begin o_ctrl.reg_write = 1'b1; o_ctrl.r31 = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_alu = ALU_SUB;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                case (i_op)
                    OP_SLTI:  o_alu = ALU_SLT;
                    OP_SLTIU: o_alu = ALU_SLTU;
                    OP_ANDI:  o_alu = ALU_AND;
                    OP_ORI:   o_alu = ALU_OR;
                    OP_XORI:  o_alu = ALU_XOR;
                    OP_LUI:   o_alu = ALU_LUI;
                    default:  o_alu = ALU_ADD;
                endcase
            end
            OP_LW: begin
                o_cls = CLS_MEM; o_alu = ALU_ADD;
                o_ctrl.alu_src = 1'b1; o_ctrl.mem_read = 1'b1;
                o_ctrl.mem_to_reg = 1'b1; o_ctrl.reg_write = 1'b1;
            end
            OP_SW: begin
                o_cls = CLS_MEM; o_alu = ALU_ADD;
                o_ctrl.alu_src = 1'b1; o_ctrl.mem_write = 1'b1;
            end
            default: o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle MIPS control FSM (FETCH/EXEC/MEM/MULDIV/HALT).
// Define CONTROL_FSM_ILLEGAL_TRAP_EN to trap unknown instructions into HALT with a sticky illegal flag.
module control_fsm
    import control_pkg::*;
#(
    parameter int MULT_LAT = 8,
    parameter int DIV_LAT  = 32
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        mem_wait,
    input  logic        halt_req,
    output logic [2:0]  state_o,
    output logic        fetch_en,
    output logic        pc_we,
    output ctrl_t       ctrl_o,
    output alu_op_t     alu_op,
    output logic        muldiv_start,
    output logic        active,
    output logic        illegal
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_ir;
    logic [5:0]  r_cnt, w_cnt_nxt;
    ctrl_t       w_dctrl;
    alu_op_t     w_dalu;
    cls_t        w_cls;
    logic        w_set_illegal;
    logic        w_unused_ir;

    // rs/rd/immediate fields belong to the datapath; the controller ignores them.
    assign w_unused_ir = ^{r_ir[25:21], r_ir[15:6]};

    control_decode u_decode (
        .i_op    (r_ir[31:26]),
        .i_rt    (r_ir[20:16]),
        .i_funct (r_ir[5:0]),
        .o_ctrl  (w_dctrl),
        .o_alu   (w_dalu),
        .o_cls   (w_cls)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_set_illegal = 1'b0;
        fetch_en      = 1'b0;
        pc_we         = 1'b0;
        ctrl_o        = '0;
        alu_op        = ALU_PASS;
        muldiv_start  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // Held low through reset so the first request follows deassertion.
                fetch_en = rst_n;
                if (instr_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                case (w_cls)
                    CLS_MEM: begin
                        ctrl_o            = w_dctrl;
                        ctrl_o.mem_read   = 1'b0;
                        ctrl_o.mem_to_reg = 1'b0;
                        ctrl_o.mem_write  = 1'b0;
                        ctrl_o.reg_write  = 1'b0;
                        alu_op            = w_dalu;
                        w_state_nxt       = ST_MEM;
                    end
                    CLS_MULDIV: begin
                        muldiv_start = 1'b1;
                        alu_op       = w_dalu;
                        w_cnt_nxt    = (w_dalu == ALU_DIV || w_dalu == ALU_DIVU) ?
                                       6'(DIV_LAT - 1) : 6'(MULT_LAT - 1);
                        w_state_nxt  = ST_MULDIV;
                    end
                    CLS_JR: begin
                        if (halt_req) begin
                            w_state_nxt = ST_HALT;
                        end else begin
                            ctrl_o      = w_dctrl;
                            alu_op      = w_dalu;
                            pc_we       = 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                    end
                    CLS_ILLEGAL: begin
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
                        w_set_illegal = 1'b1;
                        w_state_nxt   = ST_HALT;
`else
                        pc_we         = 1'b1;
                        w_state_nxt   = ST_FETCH;
`endif
                    end
                    default: begin
                        ctrl_o      = w_dctrl;
                        alu_op      = w_dalu;
                        pc_we       = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                ctrl_o           = w_dctrl;
                ctrl_o.reg_write = w_dctrl.reg_write & ~mem_wait;
                alu_op           = w_dalu;
                if (!mem_wait) begin
                    pc_we       = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_MULDIV: begin
                if (r_cnt == 6'd0) begin
                    pc_we       = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ST_FETCH && instr_valid) r_ir <= instr;
        end
    end

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_illegal <= 1'b0;
        else if (w_set_illegal) r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = w_set_illegal;
    assign illegal          = 1'b0;
`endif

    assign state_o = r_state;
    assign active  = (r_state != ST_HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Directed scoreboard bench for control_fsm: expected outputs queued per cycle, checked mid-cycle.
module tb_control_fsm;
    import control_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0, mem_wait = 1'b0, halt_req = 1'b0;
    logic [2:0]  state_o;
    logic        fetch_en, pc_we, muldiv_start, active, illegal;
    ctrl_t       ctrl_o;
    alu_op_t     alu_op;

    control_fsm #(.MULT_LAT(8), .DIV_LAT(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .mem_wait(mem_wait), .halt_req(halt_req), .state_o(state_o),
        .fetch_en(fetch_en), .pc_we(pc_we), .ctrl_o(ctrl_o), .alu_op(alu_op),
        .muldiv_start(muldiv_start), .active(active), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDU = 32'h00221821, I_LW  = 32'h8C220004, I_SW   = 32'hAC220004;
    localparam logic [31:0] I_ORI  = 32'h34220005, I_SLL = 32'h00021080, I_MTHI = 32'h00200011;
    localparam logic [31:0] I_MULT = 32'h00220018, I_DIVU = 32'h0022001B, I_JR  = 32'h03E00008;
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    typedef struct {
        string    tag;
        state_t   st;
        logic     fe, pw;
        logic [7:0] ct;
        alu_op_t  al;
        logic     ms, act;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "state",  {5'd0, state_o},      {5'd0, e.st});
        cmp(e.tag, "fetch",  {7'd0, fetch_en},     {7'd0, e.fe});
        cmp(e.tag, "pc_we",  {7'd0, pc_we},        {7'd0, e.pw});
        cmp(e.tag, "ctrl",   ctrl_o,               e.ct);
        cmp(e.tag, "alu",    {3'd0, alu_op},       {3'd0, e.al});
        cmp(e.tag, "mdstart",{7'd0, muldiv_start}, {7'd0, e.ms});
        cmp(e.tag, "active", {7'd0, active},       {7'd0, e.act});
    endtask

    // Drive one cycle's inputs just after the rising edge, queue that cycle's expected outputs,
    // then check them on the falling edge.
    task automatic step(input string tag, input logic rn, input logic iv, input logic [31:0] ins,
                        input logic mw, input logic hr, input state_t st, input logic fe,
                        input logic pw, input logic [7:0] ct, input alu_op_t al,
                        input logic ms, input logic act);
        @(posedge clk);
        #1;
        rst_n = rn; instr_valid = iv; instr = ins; mem_wait = mw; halt_req = hr;
        sb.push_back('{tag, st, fe, pw, ct, al, ms, act});
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step("rst0", 0, 0, '0, 0, 0, ST_FETCH, 0, 0, 8'h00, ALU_PASS, 0, 1);
        step("rst1", 0, 1, I_ADDU, 1, 1, ST_FETCH, 0, 0, 8'h00, ALU_PASS, 0, 1);
        cmp("rst_illegal", "illegal", {7'd0, illegal}, 8'd0);

        // ADDU, with halt_req high in EXEC (must be ignored for non-JR)
        step("f_addu", 1, 1, I_ADDU, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_addu", 1, 0, '0,     0, 1, ST_EXEC,  0, 1, 8'h84, ALU_ADD,  0, 1);

        // LW with three wait cycles; mem_wait in FETCH/EXEC is irrelevant
        step("f_lw", 1, 1, I_LW, 1, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_lw", 1, 0, '0,   1, 0, ST_EXEC,  0, 0, 8'h40, ALU_ADD,  0, 1);
        for (int i = 0; i < 3; i++)
            step("m_lw_wait", 1, 1, I_ADDU, 1, 0, ST_MEM, 0, 0, 8'h70, ALU_ADD, 0, 1);
        step("m_lw_done", 1, 0, '0, 0, 0, ST_MEM, 0, 1, 8'h74, ALU_ADD, 0, 1);

        step("f_sw", 1, 1, I_SW, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_sw", 1, 0, '0,   0, 0, ST_EXEC,  0, 0, 8'h40, ALU_ADD,  0, 1);
        step("m_sw", 1, 0, '0,   0, 0, ST_MEM,   0, 1, 8'h48, ALU_ADD,  0, 1);

        step("f_ori",  1, 1, I_ORI,  0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_ori",  1, 0, '0,     0, 0, ST_EXEC,  0, 1, 8'h44, ALU_OR,   0, 1);
        step("f_sll",  1, 1, I_SLL,  0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_sll",  1, 0, '0,     0, 0, ST_EXEC,  0, 1, 8'h85, ALU_SLL,  0, 1);
        step("f_mthi", 1, 1, I_MTHI, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_mthi", 1, 0, '0,     0, 0, ST_EXEC,  0, 1, 8'h00, ALU_PASS, 0, 1);

        // MULT: 8 MULDIV cycles, pc_we on the last; instr_valid ignored meanwhile
        step("f_mult", 1, 1, I_MULT, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_mult", 1, 0, '0,     0, 0, ST_EXEC,  0, 0, 8'h00, ALU_MULT, 1, 1);
        for (int i = 0; i < 8; i++)
            step("md_mult", 1, 1, I_ADDU, 0, 0, ST_MULDIV, 0, (i == 7), 8'h00, ALU_PASS, 0, 1);

        step("f_divu", 1, 1, I_DIVU, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_divu", 1, 0, '0,     0, 0, ST_EXEC,  0, 0, 8'h00, ALU_DIVU, 1, 1);
        for (int i = 0; i < 32; i++)
            step("md_divu", 1, 0, '0, 1, 1, ST_MULDIV, 0, (i == 31), 8'h00, ALU_PASS, 0, 1);

        // Reset in MULDIV cycle 5 aborts the divide
        step("f_divu2", 1, 1, I_DIVU, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_divu2", 1, 0, '0,     0, 0, ST_EXEC,  0, 0, 8'h00, ALU_DIVU, 1, 1);
        for (int i = 0; i < 4; i++)
            step("md_divu2", 1, 0, '0, 0, 0, ST_MULDIV, 0, 0, 8'h00, ALU_PASS, 0, 1);
        step("rst_md",  0, 0, '0,     0, 0, ST_FETCH, 0, 0, 8'h00, ALU_PASS, 0, 1);
        step("f_after", 1, 1, I_ADDU, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_after", 1, 0, '0,     0, 0, ST_EXEC,  0, 1, 8'h84, ALU_ADD,  0, 1);

        // JR with halt_req: HALT is absorbing
        step("f_jr", 1, 1, I_JR, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        step("x_jr", 1, 0, '0,   0, 1, ST_EXEC,  0, 0, 8'h00, ALU_PASS, 0, 1);
        for (int i = 0; i < 4; i++)
            step("halt", 1, (i % 2 == 0), I_ADDU, 1, 1, ST_HALT, 0, 0, 8'h00, ALU_PASS, 0, 0);
        step("rst_halt", 0, 0, '0, 0, 0, ST_FETCH, 0, 0, 8'h00, ALU_PASS, 0, 1);

        // Unknown opcode 0x3F
        step("f_bad", 1, 1, I_BAD, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        step("x_bad", 1, 0, '0, 0, 0, ST_EXEC, 0, 0, 8'h00, ALU_PASS, 0, 1);
        step("h_bad", 1, 1, I_ADDU, 0, 0, ST_HALT, 0, 0, 8'h00, ALU_PASS, 0, 0);
        cmp("bad_illegal", "illegal", {7'd0, illegal}, 8'd1);
`else
        step("x_bad", 1, 0, '0, 0, 0, ST_EXEC,  0, 1, 8'h00, ALU_PASS, 0, 1);
        step("f_post", 1, 0, '0, 0, 0, ST_FETCH, 1, 0, 8'h00, ALU_PASS, 0, 1);
        cmp("bad_illegal", "illegal", {7'd0, illegal}, 8'd0);
`endif

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
